// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter state (idle arbitration / burst lock)
//   id_width()  : width of an encoded requester index, never below 1 bit
//   Def*        : default NREQ, DWIDTH and BURST values
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } arb_state_e;

    localparam int unsigned DefNreq   = 4;
    localparam int unsigned DefDwidth = 8;
    localparam int unsigned DefBurst  = 4;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req     in  NREQ  request vector
//   rr_ptr  in  IW    highest-priority index
//   gnt     out NREQ  one-hot winner (all zero when no request)
//   gnt_idx out IW    encoded winner index (0 when no request)
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    parameter int unsigned IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic          found;
    logic [IW-1:0] idx;

    // Scan NREQ positions starting at rr_ptr, wrapping; first set request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(rr_ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the FIFO write port among
// NREQ same-clock requesters, with optional burst lock.
// Build option: define FIFO_ARB_BURST_EN to include the LOCK state (a winner
// keeps the grant for up to BURST beats); otherwise the grant rotates every beat.
//   clk       in  write-domain clock
//   rst_n     in  asynchronous active-low reset
//   req       in  NREQ        per-requester request, held with data until acked
//   wdata_in  in  NREQ*DWIDTH packed requester data, slice i at [i*DWIDTH +: DWIDTH]
//   wfull     in  FIFO full; blocks every transfer and freezes state
//   ack       out NREQ        one-hot same-cycle acknowledge
//   winc      out FIFO write increment (|ack)
//   wdata     out DWIDTH      data of the acked requester, 0 when none
//   gnt_id    out last granted requester (registered)
//   busy      out burst lock held
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ   = DefNreq,
    parameter int unsigned DWIDTH = DefDwidth,
    parameter int unsigned BURST  = DefBurst,
    localparam int unsigned IdW   = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] wdata_in,
    input  logic                   wfull,
    output logic [NREQ-1:0]        ack,
    output logic                   winc,
    output logic [DWIDTH-1:0]      wdata,
    output logic [IdW-1:0]         gnt_id,
    output logic                   busy
);

    logic [NREQ-1:0] pick_gnt;
    logic [IdW-1:0]  pick_idx;
    logic [IdW-1:0]  rr_next;
    logic [NREQ-1:0] ack_c;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  gnt_id_q, gnt_id_d;
    logic            any_req;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IdW)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    assign any_req = |req;
    assign rr_next = (pick_idx == IdW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef FIFO_ARB_BURST_EN
    arb_state_e     state_q, state_d;
    logic [IdW-1:0] owner_q, owner_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        ack_c    = '0;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        // A full FIFO freezes everything, in both states.
        if (!wfull) begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        ack_c    = pick_gnt;
                        rr_ptr_d = rr_next;
                        gnt_id_d = pick_idx;
                        if (BURST > 1) begin
                            state_d = StLock;
                            owner_d = pick_idx;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                StLock: begin
                    // rr_ptr already points past the owner; bursts never move it.
                    if (req[owner_q]) begin
                        ack_c[owner_q] = 1'b1;
                        if (cnt_inc == 8'(BURST)) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc;
                        end
                    end else begin
                        // Owner gave up early: one bubble, then re-arbitrate.
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StLock);
`else
    logic unused_burst;

    always_comb begin
        ack_c    = '0;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        if (!wfull && any_req) begin
            ack_c    = pick_gnt;
            rr_ptr_d = rr_next;
            gnt_id_d = pick_idx;
        end
    end

    assign busy         = 1'b0;
    assign unused_burst = ^BURST;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    // Outputs are suppressed combinationally while reset is asserted.
    assign ack    = ack_c & {NREQ{rst_n}};
    assign winc   = |ack;
    assign gnt_id = gnt_id_q;

    always_comb begin
        wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            wdata = wdata | (wdata_in[i*DWIDTH +: DWIDTH] & {DWIDTH{ack[i]}});
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DWIDTH = 8;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] wdata;
        logic       busy;
        logic [1:0] gnt;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*DWIDTH-1:0] wdata_in;
    logic                   wfull;
    logic [NREQ-1:0]        ack;
    logic                   winc;
    logic [DWIDTH-1:0]      wdata;
    logic [1:0]             gnt_id;
    logic                   busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    fifo_wr_arbiter #(
        .NREQ   (NREQ),
        .DWIDTH (DWIDTH),
        .BURST  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata_in (wdata_in),
        .wfull    (wfull),
        .ack      (ack),
        .winc     (winc),
        .wdata    (wdata),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack", 32'(ack), 32'(e.ack));
            chk("winc", 32'(winc), 32'(|e.ack));
            chk("wdata", 32'(wdata), 32'(e.wdata));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("gnt_id", 32'(gnt_id), 32'(e.gnt));
        end
    end

    // Drive one cycle and queue its expected response (idx -1 = no ack).
    task automatic step(input logic [3:0] r, input logic wf, input logic rn,
                        input int idx, input logic eb, input logic [1:0] eg);
        exp_t e;
        req   = r;
        wfull = wf;
        rst_n = rn;
        e.ack   = (idx >= 0) ? (4'b0001 << idx) : 4'b0000;
        e.wdata = (idx >= 0) ? (8'hA0 + 8'(idx)) : 8'h00;
        e.busy  = eb;
        e.gnt   = eg;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        wfull    = 1'b0;
        wdata_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(posedge clk);
        #1;

        // Reset with all requests high: outputs forced to zero.
        step(4'b1111, 1'b0, 1'b0, -1, 1'b0, 2'd0);
        step(4'b1111, 1'b0, 1'b0, -1, 1'b0, 2'd0);

`ifdef FIFO_ARB_BURST_EN
        // Release: requester 0 acked immediately, burst of 4.
        step(4'b1111, 1'b0, 1'b1, 0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1, 0, 1'b1, 2'd0);
        // req=0110: 4 beats of 1, then 4 beats of 2.
        step(4'b0110, 1'b0, 1'b1, 1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step(4'b0110, 1'b0, 1'b1, 1, 1'b1, 2'd1);
        step(4'b0110, 1'b0, 1'b1, 2, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) step(4'b0110, 1'b0, 1'b1, 2, 1'b1, 2'd2);
        // Full stall inside burst of requester 3; still exactly 4 beats.
        step(4'b1111, 1'b0, 1'b1, 3, 1'b0, 2'd2);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b1, -1, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1, 3, 1'b1, 2'd3);
        // Early release after beat 2, one bubble, then owner+1.
        step(4'b0011, 1'b0, 1'b1, 0, 1'b0, 2'd3);
        step(4'b0011, 1'b0, 1'b1, 0, 1'b1, 2'd0);
        step(4'b0010, 1'b0, 1'b1, -1, 1'b1, 2'd0);
        step(4'b0010, 1'b0, 1'b1, 1, 1'b0, 2'd0);
        step(4'b0010, 1'b0, 1'b1, 1, 1'b1, 2'd1);
        // Reset on beat 3: lock dropped, restart at index 0.
        step(4'b0010, 1'b0, 1'b0, -1, 1'b0, 2'd0);
        step(4'b1111, 1'b0, 1'b1, 0, 1'b0, 2'd0);
        step(4'b0000, 1'b0, 1'b1, -1, 1'b1, 2'd0);
        step(4'b0000, 1'b0, 1'b1, -1, 1'b0, 2'd0);
`else
        // Release and rotate every beat: 0,1,2,3,0,1,2,3.
        step(4'b1111, 1'b0, 1'b1, 0, 1'b0, 2'd0);
        step(4'b1111, 1'b0, 1'b1, 1, 1'b0, 2'd0);
        step(4'b1111, 1'b0, 1'b1, 2, 1'b0, 2'd1);
        step(4'b1111, 1'b0, 1'b1, 3, 1'b0, 2'd2);
        step(4'b1111, 1'b0, 1'b1, 0, 1'b0, 2'd3);
        step(4'b1111, 1'b0, 1'b1, 1, 1'b0, 2'd0);
        step(4'b1111, 1'b0, 1'b1, 2, 1'b0, 2'd1);
        step(4'b1111, 1'b0, 1'b1, 3, 1'b0, 2'd2);
        // Full stall freezes the pointer; falling wfull transfers same cycle.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b1, -1, 1'b0, 2'd3);
        step(4'b1111, 1'b0, 1'b1, 0, 1'b0, 2'd3);
        // Sparse requests skip idle slots with wrap.
        step(4'b1010, 1'b0, 1'b1, 1, 1'b0, 2'd0);
        step(4'b1010, 1'b0, 1'b1, 3, 1'b0, 2'd1);
        step(4'b1010, 1'b0, 1'b1, 1, 1'b0, 2'd3);
        step(4'b0000, 1'b0, 1'b1, -1, 1'b0, 2'd1);
        step(4'b0001, 1'b0, 1'b1, 0, 1'b0, 2'd1);
        // Reset pulse with pointer at 1: restart at index 0.
        step(4'b1111, 1'b0, 1'b0, -1, 1'b0, 2'd0);
        step(4'b1111, 1'b0, 1'b1, 0, 1'b0, 2'd0);
        step(4'b0000, 1'b0, 1'b1, -1, 1'b0, 2'd0);
`endif

        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
